// File: rtl/fully_connected_pipe.sv
// Pipelined fully-connected layer: streams one weight burst per cycle, multiplies
// PARALLEL_MACS lanes per cycle and reduces them through a registered adder tree.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_FETCH   | issue weight bursts, capture burst data and bias
// S_COMPUTE | one MAC iteration per cycle into the adder tree
// S_DRAIN   | flush the adder tree into the accumulator
// S_WRITE   | add bias, optional ReLU, write layer_out[n]
// S_DONE    | pulse done, return to idle
module fully_connected_pipe #(
   parameter int INPUT_SIZE    = 512,
   parameter int OUTPUT_SIZE   = 256,
   parameter int WEIGHTS_WIDTH = 8,
   parameter int BURST_LEN     = 4,
   parameter int BIAS_WIDTH    = 32,
   parameter int PARALLEL_MACS = 16,
   parameter int RD_LAT        = 2,
   parameter int RELU_EN       = 0,
   localparam int AW = (INPUT_SIZE * OUTPUT_SIZE > 1) ? $clog2(INPUT_SIZE * OUTPUT_SIZE) : 1,
   localparam int NW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   output logic                                  busy,
   output logic                                  done,
   input  logic signed [WEIGHTS_WIDTH-1:0]       inputs [INPUT_SIZE],
   output logic                                  w_read_en,
   output logic [AW-1:0]                         w_read_addr,
   input  logic [BURST_LEN*WEIGHTS_WIDTH-1:0]    w_read_data,
   output logic                                  b_read_en,
   output logic [NW-1:0]                         b_read_addr,
   input  logic signed [BIAS_WIDTH-1:0]          b_read_data,
   output logic                                  node_valid,
   output logic [NW-1:0]                         node_idx,
   output logic signed [BIAS_WIDTH-1:0]          layer_out [OUTPUT_SIZE]
);

   localparam int WW = WEIGHTS_WIDTH;
   localparam int BW = BIAS_WIDTH;
   localparam int P  = PARALLEL_MACS;
   localparam int NB = (INPUT_SIZE + BURST_LEN - 1) / BURST_LEN;
   localparam int MI = (INPUT_SIZE + P - 1) / P;
   localparam int TD = $clog2(P);
   localparam int CW = $clog2(NB + RD_LAT + MI + TD + 2) + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_COMPUTE, S_DRAIN, S_WRITE, S_DONE
   } state_t;

   state_t                  state;
   logic [CW-1:0]           cnt;
   logic [NW-1:0]           n_cur;
   logic [AW-1:0]           base;
   logic signed [WW-1:0]    wbuf  [INPUT_SIZE];
   logic signed [WW-1:0]    a_pad [MI*P];
   logic signed [WW-1:0]    w_pad [MI*P];
   logic signed [2*WW-1:0]  mul   [P];
   logic signed [BW-1:0]    prod  [P];
   logic signed [BW-1:0]    node  [1:P-1];
   logic signed [BW-1:0]    tv    [1:2*P-1];
   logic [TD-1:0]           vld;
   logic signed [BW-1:0]    bias_q;
   logic signed [BW-1:0]    acc;
   logic signed [BW-1:0]    sum_r;
   logic signed [BW-1:0]    res;

   // Pad the operand vectors to a whole number of iterations; padding lanes are zero.
   for (genvar e = 0; e < MI * P; e++) begin : g_pad
      if (e < INPUT_SIZE) begin : g_in
         assign a_pad[e] = inputs[e];
         assign w_pad[e] = wbuf[e];
      end else begin : g_zero
         assign a_pad[e] = '0;
         assign w_pad[e] = '0;
      end
   end

   always_comb begin
      for (int k = 0; k < P; k++) begin
         mul[k] = '0;
         for (int m = 0; m < MI; m++) begin
            if (state == S_COMPUTE && int'(cnt) == m)
               mul[k] = a_pad[m*P + k] * w_pad[m*P + k];
         end
         prod[k] = BW'(mul[k]);
      end
   end

   // Heap-ordered tree: tv[1..P-1] are registered nodes, tv[P..2P-1] are the products.
   always_comb begin
      for (int i = 1; i < P; i++)
         tv[i] = node[i];
      for (int k = 0; k < P; k++)
         tv[P + k] = prod[k];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i < P; i++)
            node[i] <= '0;
         vld <= '0;
      end else begin
         for (int i = 1; i < P; i++)
            node[i] <= tv[2*i] + tv[2*i + 1];
         vld[0] <= (state == S_COMPUTE);
         for (int i = 1; i < TD; i++)
            vld[i] <= vld[i-1];
      end
   end

   // Burst b lands RD_LAT+1 FETCH cycles after it was issued; bias rides with burst 0.
   always_ff @(posedge clk) begin
      if (state == S_FETCH && int'(cnt) >= RD_LAT) begin
         for (int e = 0; e < INPUT_SIZE; e++) begin
            if (int'(cnt) - RD_LAT == e / BURST_LEN)
               wbuf[e] <= w_read_data[(BURST_LEN - 1 - e % BURST_LEN)*WW +: WW];
         end
         if (int'(cnt) == RD_LAT)
            bias_q <= b_read_data;
      end
   end

   always_comb begin
      sum_r = acc + bias_q;
      res   = sum_r;
      if (RELU_EN != 0 && sum_r[BW-1])
         res = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         n_cur       <= '0;
         base        <= '0;
         acc         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         node_valid  <= 1'b0;
         node_idx    <= '0;
         w_read_en   <= 1'b0;
         w_read_addr <= '0;
         b_read_en   <= 1'b0;
         b_read_addr <= '0;
         for (int n = 0; n < OUTPUT_SIZE; n++)
            layer_out[n] <= '0;
      end else begin
         done       <= 1'b0;
         node_valid <= 1'b0;
         b_read_en  <= 1'b0;
         if (vld[TD-1])
            acc <= acc + tv[1];
         case (state)
            S_IDLE: begin
               if (start) begin
                  state       <= S_FETCH;
                  busy        <= 1'b1;
                  cnt         <= '0;
                  n_cur       <= '0;
                  base        <= '0;
                  w_read_en   <= 1'b1;
                  w_read_addr <= '0;
                  b_read_en   <= 1'b1;
                  b_read_addr <= '0;
               end
            end
            S_FETCH: begin
               if (int'(cnt) + 1 < NB)
                  w_read_addr <= w_read_addr + AW'(BURST_LEN);
               else
                  w_read_en <= 1'b0;
               if (int'(cnt) == NB + RD_LAT - 1) begin
                  state <= S_COMPUTE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_COMPUTE: begin
               if (int'(cnt) == MI - 1) begin
                  state <= S_DRAIN;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_DRAIN: begin
               if (int'(cnt) == TD - 1) begin
                  state <= S_WRITE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_WRITE: begin
               layer_out[n_cur] <= res;
               node_valid       <= 1'b1;
               node_idx         <= n_cur;
               acc              <= '0;
               if (n_cur == NW'(OUTPUT_SIZE - 1)) begin
                  state <= S_DONE;
               end else begin
                  state       <= S_FETCH;
                  cnt         <= '0;
                  n_cur       <= n_cur + 1'b1;
                  base        <= base + AW'(INPUT_SIZE);
                  w_read_en   <= 1'b1;
                  w_read_addr <= base + AW'(INPUT_SIZE);
                  b_read_en   <= 1'b1;
                  b_read_addr <= n_cur + 1'b1;
               end
            end
            S_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
